mem_slave_pipe: RTL

- Parametrised single-port memory slave that sits behind the mem_if agent's addr/wr_en/rd_en/wdata/rdata signal set; successor to the fixed 32-bit, zero-handshake memory model.
- Adds a valid/ready request handshake, byte-strobed writes, a configurable read-latency pipeline, out-of-range error reporting and a post-reset clear sequence.

---
 rtl/mem_slave_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_slave_pipe.sv
// Single-port memory slave: valid/ready requests, byte-strobed writes, RD_LATENCY read pipeline,
// out-of-range error responses and a post-reset clear sweep. `MEM_SLAVE_STATS_EN adds traffic counters.
module mem_slave_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rvalid,
  output logic                      rerr
`ifdef MEM_SLAVE_STATS_EN
  ,
  output logic [15:0]               wr_cnt,
  output logic [15:0]               rd_cnt,
  output logic [15:0]               err_cnt
`endif
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  state_t                  state;
  logic [IDX_W-1:0]        clear_idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [IDX_W-1:0]        idx;
  logic                    oob, acc, rd_acc, rd_err, wr_commit;
  rsp_t                    rsp_in;
  logic [RD_LATENCY:1]     vld_pipe;
  rsp_t                    rsp_pipe [RD_LATENCY:1];

  // Range check uses the full address so aliases of low words are rejected.
  assign word_addr = addr >> OFF;
  assign idx       = word_addr[IDX_W-1:0];
  assign oob       = (word_addr >= ADDR_WIDTH'(DEPTH));
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & rd_en;
  assign rd_err    = oob | wr_en;
  assign wr_commit = acc & wr_en & ~rd_en & ~oob;

  always_comb begin
    rsp_in = '0;
    if (rd_acc) begin
      rsp_in.err = rd_err;
      if (!rd_err) rsp_in.data = mem[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      clear_idx <= '0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end
        end
        RUN:     req_ready <= 1'b1;
        default: state     <= INIT;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clear_idx] <= '0;
    end else if (wr_commit) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Idle stages carry zero payload, so rdata/rerr are 0 whenever rvalid is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= RD_LATENCY; i++) rsp_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      rsp_pipe[1] <= rsp_in;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign rvalid = vld_pipe[RD_LATENCY];
  assign rdata  = rsp_pipe[RD_LATENCY].data;
  assign rerr   = rsp_pipe[RD_LATENCY].err;

`ifdef MEM_SLAVE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_commit && wr_cnt != 16'hFFFF)          wr_cnt  <= wr_cnt + 1'b1;
      if (rd_acc && !wr_en && rd_cnt != 16'hFFFF)   rd_cnt  <= rd_cnt + 1'b1;
      if (rvalid && rerr && err_cnt != 16'hFFFF)    err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
